// File: rtl/intr_ctrl_nested_if.sv
// Bundle of source, mask, fetch-handshake and nesting-status signals for the nested interrupt controller.
// The controller uses the slave modport; sources/fetch control use the master modport.
interface intr_ctrl_nested_if #(
  parameter int P_NUM_HARD   = 8,
  parameter int P_CODE_BITS  = 4,
  parameter int P_DEPTH_BITS = 2
);
  logic [P_NUM_HARD-1:0]   i_h_intr;
  logic                    i_s_intr;
  logic [P_CODE_BITS-1:0]  i_s_intr_code;
  logic                    i_gie;
  logic                    i_mask_we;
  logic [P_NUM_HARD-1:0]   i_mask_wdata;
  logic [P_NUM_HARD-1:0]   o_mask;
  logic [P_NUM_HARD-1:0]   o_pending;
  logic                    o_intr_req;
  logic                    i_intr_ack;
  logic [P_CODE_BITS:0]    o_intr_code;
  logic                    i_intr_finish;
  logic [P_DEPTH_BITS-1:0] o_depth;
  logic                    o_intring;
  logic                    o_nest_overflow;

  modport master (
    output i_h_intr, i_s_intr, i_s_intr_code, i_gie, i_mask_we, i_mask_wdata,
           i_intr_ack, i_intr_finish,
    input  o_mask, o_pending, o_intr_req, o_intr_code, o_depth, o_intring, o_nest_overflow
  );

  modport slave (
    input  i_h_intr, i_s_intr, i_s_intr_code, i_gie, i_mask_we, i_mask_wdata,
           i_intr_ack, i_intr_finish,
    output o_mask, o_pending, o_intr_req, o_intr_code, o_depth, o_intring, o_nest_overflow
  );
endinterface

// File: rtl/intr_ctrl_nested.sv
// Nested interrupt controller: edge-latched maskable hard lines with fixed priority, one soft channel,
// and a priority stack whose depth selects the shadow bank used by fetch, FIFOs and the register file.
module intr_ctrl_nested #(
  parameter int P_NUM_HARD   = 8,
  parameter int P_CODE_BITS  = 4,
  parameter int P_NEST_DEPTH = 2,
  parameter int P_DEPTH_BITS = 2
) (
  input logic               clk,
  input logic               rst,
  intr_ctrl_nested_if.slave bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;
  localparam logic [P_DEPTH_BITS-1:0] DEPTH_MAX = P_DEPTH_BITS'(P_NEST_DEPTH);

  logic [0:0]              state_reg;
  logic [P_NUM_HARD-1:0]   h_prev_reg, pending_reg, mask_reg;
  logic [P_NUM_HARD-1:0]   h_rise, eligible, pending_next;
  logic                    soft_pend_reg;
  logic [P_CODE_BITS-1:0]  soft_code_reg;
  logic [P_DEPTH_BITS-1:0] depth_reg, depth_next, push_slot;
  // Stack entries use the same {soft, index} format as the request code.
  logic [P_CODE_BITS:0]    stack_reg [P_NEST_DEPTH];
  logic [P_CODE_BITS:0]    top_entry;
  logic                    req_reg, intring_reg, ovf_reg;
  logic [P_CODE_BITS:0]    code_reg;
  logic                    hard_found, room, top_allows, soft_cand, hard_cand, overflow;
  logic                    do_ack, do_pop;
  logic [P_CODE_BITS-1:0]  hard_idx;

  assign h_rise   = bus.i_h_intr & ~h_prev_reg;
  assign eligible = pending_reg & mask_reg & {P_NUM_HARD{bus.i_gie}};

  always_comb begin
    hard_found = 1'b0;
    hard_idx   = '0;
    for (int i = P_NUM_HARD - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        hard_found = 1'b1;
        hard_idx   = P_CODE_BITS'(i);
      end
    end
  end

  always_comb begin
    top_entry = '0;
    for (int k = 0; k < P_NEST_DEPTH; k++) begin
      if (P_DEPTH_BITS'(k + 1) == depth_reg) top_entry = stack_reg[k];
    end
  end

  assign room       = (depth_reg < DEPTH_MAX);
  assign top_allows = (depth_reg == '0) ||
                      (!top_entry[P_CODE_BITS] && (top_entry[P_CODE_BITS-1:0] > hard_idx));
  assign soft_cand  = soft_pend_reg && room;
  assign hard_cand  = hard_found && room && top_allows;
  assign overflow   = soft_pend_reg && (depth_reg == DEPTH_MAX);

  assign do_ack     = (state_reg == ST_REQ) && bus.i_intr_ack;
  assign do_pop     = bus.i_intr_finish && (depth_reg != '0);
  // A simultaneous pop frees the top slot, so the push lands there.
  assign push_slot  = depth_reg - P_DEPTH_BITS'(do_pop);
  assign depth_next = depth_reg - P_DEPTH_BITS'(do_pop) + P_DEPTH_BITS'(do_ack);

  // A fresh edge wins over the acknowledge clearing the same bit.
  for (genvar gi = 0; gi < P_NUM_HARD; gi++) begin : g_pend
    assign pending_next[gi] = h_rise[gi] ||
        (pending_reg[gi] &&
         !(do_ack && !code_reg[P_CODE_BITS] && (code_reg[P_CODE_BITS-1:0] == P_CODE_BITS'(gi))));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < P_NEST_DEPTH; k++) stack_reg[k] <= '0;
    end else if (do_ack) begin
      for (int k = 0; k < P_NEST_DEPTH; k++) begin
        if (push_slot == P_DEPTH_BITS'(k)) stack_reg[k] <= code_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      h_prev_reg    <= '0;
      pending_reg   <= '0;
      mask_reg      <= '0;
      soft_pend_reg <= 1'b0;
      soft_code_reg <= '0;
      depth_reg     <= '0;
      intring_reg   <= 1'b0;
      ovf_reg       <= 1'b0;
      req_reg       <= 1'b0;
      code_reg      <= '0;
    end else begin
      h_prev_reg  <= bus.i_h_intr;
      pending_reg <= pending_next;
      depth_reg   <= depth_next;
      intring_reg <= (depth_next != '0);
      ovf_reg     <= overflow;
      if (bus.i_mask_we) mask_reg <= bus.i_mask_wdata;
      if (bus.i_s_intr) begin
        soft_pend_reg <= 1'b1;
        soft_code_reg <= bus.i_s_intr_code;
      end else if (overflow || (do_ack && code_reg[P_CODE_BITS])) begin
        soft_pend_reg <= 1'b0;
      end
      case (state_reg)
        ST_IDLE: begin
          if (soft_cand) begin
            code_reg  <= {1'b1, soft_code_reg};
            req_reg   <= 1'b1;
            state_reg <= ST_REQ;
          end else if (hard_cand) begin
            code_reg  <= {1'b0, hard_idx};
            req_reg   <= 1'b1;
            state_reg <= ST_REQ;
          end
        end
        default: begin
          if (bus.i_intr_ack) begin
            req_reg   <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.o_mask          = mask_reg;
  assign bus.o_pending       = pending_reg;
  assign bus.o_intr_req      = req_reg;
  assign bus.o_intr_code     = code_reg;
  assign bus.o_depth         = depth_reg;
  assign bus.o_intring       = intring_reg;
  assign bus.o_nest_overflow = ovf_reg;

endmodule

// File: doc/intr_ctrl_nested.md
Name: intr_ctrl_nested

Overview:
- Parametrised interrupt controller; successor to the single-level hard/soft interrupt logic in the CPU top.
- Supports P_NUM_HARD maskable hard lines with fixed priority, one soft-interrupt channel, and nesting up to P_NEST_DEPTH levels.
- Nesting depth drives shadow-bank select (o_depth) for the register file, instruction FIFOs and fetch control.
- Sits between external interrupt sources and instruction fetch control; handshakes each accepted interrupt with the fetch side.

Parameters:
- P_NUM_HARD, 8, number of hard interrupt lines; line 0 has the highest priority.
- P_CODE_BITS, 4, code field width; must satisfy 2^P_CODE_BITS >= P_NUM_HARD.
- P_NEST_DEPTH, 2, maximum nesting levels (number of shadow banks).
- P_DEPTH_BITS, 2, width of depth counter; must satisfy 2^P_DEPTH_BITS > P_NEST_DEPTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset (see Behaviour)
- i_h_intr  in  P_NUM_HARD  hard interrupt lines, rising-edge sensitive
- i_s_intr  in  1  soft interrupt request pulse
- i_s_intr_code  in  P_CODE_BITS  soft code, sampled with i_s_intr
- i_gie  in  1  global interrupt enable
- i_mask_we  in  1  mask register write strobe
- i_mask_wdata  in  P_NUM_HARD  new mask; 1 = line enabled
- o_mask  out  P_NUM_HARD  current mask
- o_pending  out  P_NUM_HARD  latched hard pending bits
- o_intr_req  out  1  interrupt request to fetch control
- i_intr_ack  in  1  fetch control has redirected to the handler
- o_intr_code  out  P_CODE_BITS+1  {soft flag, code}; hard code = line index
- i_intr_finish  in  1  return-from-interrupt pulse
- o_depth  out  P_DEPTH_BITS  current nesting level = shadow bank select
- o_intring  out  1  o_depth != 0
- o_nest_overflow  out  1  one-cycle pulse: soft request dropped because the stack is full

Behaviour:
- Reset is synchronous, active-high (rst) on clock clk.
- Reset values: mask all 0, all pending bits 0, soft pending 0, depth 0, stack cleared, state IDLE; all outputs 0.
- Edge detect:
  - Previous i_h_intr is registered (reset 0).
  - A rising edge sets pending[i] next cycle, regardless of mask.
  - If a set and a clear hit the same bit in the same cycle, set wins.
- Soft pending:
  - i_s_intr sets soft pending and captures the code next cycle.
  - A new i_s_intr while soft pending is set overwrites the code.
- Mask: i_mask_we updates o_mask next cycle; the new value is used for selection from that cycle on.
- Stack:
  - P_NEST_DEPTH entries; each entry holds a priority: hard line index, or SOFT (higher than every hard line).
  - Top entry = entry at index depth-1.
- Candidate selection (combinational, evaluated in IDLE), in order:
  1. If soft pending and depth < P_NEST_DEPTH: the soft interrupt is the candidate (ignores i_gie and mask).
  2. Otherwise, the lowest index i with pending[i] & mask[i] & i_gie is a candidate only if depth < P_NEST_DEPTH and (depth == 0 or the top entry is hard with index > i).
- Overflow: soft pending with depth == P_NEST_DEPTH → o_nest_overflow pulses one cycle and soft pending clears.
- FSM IDLE:
  - Candidate exists → register o_intr_code; go to REQ; o_intr_req = 1 from the next cycle.
- FSM REQ:
  - o_intr_req and o_intr_code held stable until i_intr_ack.
  - On ack: push priority, depth += 1, clear the source's pending bit (hard bit or soft pending), return to IDLE, o_intr_req = 0.
  - Minimum one IDLE cycle between requests.
  - The hard candidate is locked at REQ entry; a higher-priority edge during REQ waits for the next IDLE.
- i_intr_finish:
  - depth > 0 → pop, depth −= 1 next cycle.
  - depth == 0 → ignored.
  - Allowed in any state.
  - Finish and ack in the same cycle: pop first, then push into the freed slot; net depth unchanged, top = new entry.
- Masking a line while it is in REQ does not retract the request.
- i_intr_ack outside REQ is ignored.
- rst mid-REQ returns to reset state; requests not acknowledged are lost.
- o_intring = (depth != 0), registered.

Test Plan:
1. Reset, mask = 0xFF, gie = 1, edge on line 3 → pending = 0x08; o_intr_req rises 2 cycles after the edge with code 0x03; ack → pending 0, depth 1, o_intring 1.
2. Depth 1 serving line 3; edge on line 5 → no request; edge on line 1 → request code 0x01; ack → depth 2; finish ×2 → depth 0, line 5 is then requested.
3. Mask = 0x00, edges on lines 0 and 7 → pending = 0x81, no request; write mask = 0x80 → request code 0x07.
4. Soft code 0x9 with depth 0 and gie = 0 → request code 0x19; ack → depth 1; hard line 0 edge → not requested until finish.
5. Fill the stack (depth = P_NEST_DEPTH = 2), then assert soft → o_nest_overflow one pulse, depth stays 2, no request.
6. Assert i_intr_finish and i_intr_ack together at depth 1 → depth stays 1, top entry = new source; later finish → depth 0; reset during REQ → o_intr_req 0, pending 0.
